// File: rtl/as512512512_spi_slave_if.sv
// SPI pins plus core-side transmit/receive handshake for the SPI slave endpoint.
interface as512512512_spi_slave_if;
    localparam int unsigned DATA_W = 8;

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              underrun;
    logic              clr_flags;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_load, clr_flags,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_load, clr_flags,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, busy
    );
endinterface

// File: rtl/as512512512_spi_slave.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled pins, one-byte tx holding buffer.
module as512512512_spi_slave #(
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    as512512512_spi_slave_if.slave      bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_h;
    logic                   cs_h;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]  shift_out;
    logic [BYTE_W-1:0]  rx_shift;
    logic [BYTE_W-1:0]  tx_buf;
    logic               tx_ready_q;
    logic [BYTE_W-1:0]  rx_data_q;
    logic               rx_valid_q;
    logic               underrun_q;
    logic               miso_q;
    logic               miso_oe_q;
    logic               busy_q;

    logic               sclk_s_c;
    logic               cs_s_c;
    logic               mosi_s_c;
    logic               sclk_rise_c;
    logic               sclk_fall_c;
    logic               cs_fall_c;
    logic               cs_rise_c;
    logic               drain_c;
    logic [BYTE_W-1:0]  reload_c;

    // Pin synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_h    <= 1'b0;
            cs_h      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_h    <= sclk_sync[SYNC_STAGES-1];
            cs_h      <= cs_sync[SYNC_STAGES-1];
        end
    end

    // Edge detection and buffer-drain decision (frame start or byte boundary)
    always_comb begin
        sclk_s_c    = sclk_sync[SYNC_STAGES-1];
        cs_s_c      = cs_sync[SYNC_STAGES-1];
        mosi_s_c    = mosi_sync[SYNC_STAGES-1];
        sclk_rise_c = sclk_s_c & ~sclk_h;
        sclk_fall_c = ~sclk_s_c & sclk_h;
        cs_fall_c   = ~cs_s_c & cs_h;
        cs_rise_c   = cs_s_c & ~cs_h;
        drain_c     = ((state == ST_IDLE) && cs_fall_c) ||
                      ((state == ST_ACTIVE) && !cs_rise_c && sclk_fall_c && (bit_cnt == '0));
        reload_c    = tx_ready_q ? IDLE_BYTE : tx_buf;
    end

    // Frame FSM, shift registers, holding buffer and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_out  <= '0;
            rx_shift   <= '0;
            tx_buf     <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            // A new underrun outranks a simultaneous clear
            if (bus.clr_flags) underrun_q <= 1'b0;
            if (drain_c && tx_ready_q) underrun_q <= 1'b1;

            // Load is judged on the pre-drain buffer state
            if (bus.tx_load && tx_ready_q) begin
                tx_buf     <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end else if (drain_c && !tx_ready_q) begin
                tx_ready_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall_c) begin
                        state     <= ST_ACTIVE;
                        bit_cnt   <= '0;
                        shift_out <= reload_c;
                        miso_q    <= reload_c[BYTE_W-1];
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise_c) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (sclk_rise_c) begin
                        rx_shift <= {rx_shift[BYTE_W-2:0], mosi_s_c};
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            rx_data_q  <= {rx_shift[BYTE_W-2:0], mosi_s_c};
                            rx_valid_q <= 1'b1;
                        end
                    end else if (sclk_fall_c) begin
                        if (bit_cnt == '0) begin
                            shift_out <= reload_c;
                            miso_q    <= reload_c[BYTE_W-1];
                        end else begin
                            shift_out <= {shift_out[BYTE_W-2:0], 1'b0};
                            miso_q    <= shift_out[BYTE_W-2];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = miso_oe_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.underrun = underrun_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_as512512512_spi_slave.sv
// Directed bench: bench-side SPI master plus a frame-level model of the holding buffer.
module tb_as512512512_spi_slave;
    localparam int unsigned H = 4;
    localparam logic [7:0] IDLE_B = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    as512512512_spi_slave_if bus();

    as512512512_spi_slave #(.IDLE_BYTE(IDLE_B), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: holding buffer, sticky flag, bytes the master will complete
    bit         mdl_full = 1'b0;
    logic [7:0] mdl_buf  = 8'h00;
    bit         mdl_underrun = 1'b0;
    logic [7:0] exp_rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_load = 1'b1;
        if (!mdl_full) begin
            mdl_full = 1'b1;
            mdl_buf  = b;
        end
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_flags = 1'b1;
        mdl_underrun  = 1'b0;
        @(negedge clk);
        bus.clr_flags = 1'b0;
    endtask

    task automatic mdl_drain(output logic [7:0] d);
        if (mdl_full) begin
            d = mdl_buf;
            mdl_full = 1'b0;
        end else begin
            d = IDLE_B;
            mdl_underrun = 1'b1;
        end
    endtask

    // One cs_n-low transaction of nbits; last sclk fall coincides with cs_n rise
    task automatic spi_xfer(input logic [15:0] mo, input int nbits, input bit mid_load,
                            input logic [7:0] mid_byte, output logic [15:0] mi);
        logic [7:0]  cur;
        logic [15:0] exp_mi;
        mi = '0;
        exp_mi = '0;
        cur = '0;
        for (int k = nbits / 8 - 1; k >= 0; k--) exp_rx.push_back(mo[8*k +: 8]);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.mosi = mo[nbits-1];
        cyc(2 * H);
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) mdl_drain(cur);
            exp_mi = {exp_mi[14:0], cur[7 - (i % 8)]};
            if (i == 0) begin
                check("tx_ready_in_frame", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
                check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
            end
            if (mid_load && i == 3) begin
                load_byte(mid_byte);
                cyc(H - 2);
            end else begin
                cyc(H);
            end
            bus.sclk = 1'b1;
            mi = {mi[14:0], bus.miso};
            cyc(H);
            bus.sclk = 1'b0;
            if (i == nbits - 1) bus.cs_n = 1'b1;
            else bus.mosi = mo[nbits-2-i];
        end
        cyc(2 * H + 4);
        check("miso_bits", {16'd0, mi}, {16'd0, exp_mi});
        check("tx_ready_after", {31'd0, bus.tx_ready}, {31'd0, !mdl_full});
        check("underrun_after", {31'd0, bus.underrun}, {31'd0, mdl_underrun});
        check("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    // Per-cycle compare: pin idle behaviour and every rx_valid against the model queue
    always @(negedge clk) begin
        if (rst) begin
            check("oe_tracks_busy", {31'd0, bus.miso_oe}, {31'd0, bus.busy});
            if (!bus.busy) check("miso_idle_low", {31'd0, bus.miso}, 32'd0);
            if (bus.rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", {31'd0, bus.rx_valid}, 32'd0);
                else check("rx_data_strobe", {24'd0, bus.rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
    end

    logic [15:0] mi;

    initial begin
        rst = 1'b0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        bus.clr_flags = 1'b0;
        cyc(3);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_underrun", {31'd0, bus.underrun}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        rst = 1'b1;
        cyc(4);

        // Preloaded single frame
        load_byte(8'h3C);
        check("t1_tx_ready_loaded", {31'd0, bus.tx_ready}, 32'd0);
        spi_xfer(16'h00A5, 8, 1'b0, 8'h00, mi);
        check("t1_miso_lit", {24'd0, mi[7:0]}, 32'h3C);
        check("t1_rx_lit", {24'd0, bus.rx_data}, 32'hA5);
        check("t1_underrun_lit", {31'd0, bus.underrun}, 32'd0);

        // Empty buffer: idle byte and sticky underrun, then clear
        spi_xfer(16'h0000, 8, 1'b0, 8'h00, mi);
        check("t2_miso_lit", {24'd0, mi[7:0]}, 32'hFF);
        check("t2_underrun_lit", {31'd0, bus.underrun}, 32'd1);
        clr_pulse();
        cyc(2);
        check("t2_clr_lit", {31'd0, bus.underrun}, 32'd0);

        // Back-to-back bytes under one cs_n, second byte loaded mid-frame
        load_byte(8'h12);
        spi_xfer(16'h817E, 16, 1'b1, 8'h34, mi);
        check("t3_miso_lit", {16'd0, mi}, 32'h1234);
        check("t3_rx_lit", {24'd0, bus.rx_data}, 32'h7E);
        check("t3_underrun_lit", {31'd0, bus.underrun}, 32'd0);

        // Aborted frame after 4 bits, then a fresh full frame
        spi_xfer(16'h000C, 4, 1'b0, 8'h00, mi);
        check("t4_abort_miso_lit", {28'd0, mi[3:0]}, 32'hF);
        check("t4_abort_rx_held", {24'd0, bus.rx_data}, 32'h7E);
        spi_xfer(16'h005A, 8, 1'b0, 8'h00, mi);
        check("t4_rx_lit", {24'd0, bus.rx_data}, 32'h5A);
        clr_pulse();

        // Second load while full is dropped
        load_byte(8'h11);
        load_byte(8'h22);
        check("t5_tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
        spi_xfer(16'h003E, 8, 1'b0, 8'h00, mi);
        check("t5_miso_lit", {24'd0, mi[7:0]}, 32'h11);
        check("t5_tx_ready_lit", {31'd0, bus.tx_ready}, 32'd1);
        check("t5_underrun_lit", {31'd0, bus.underrun}, 32'd0);

        // Async reset mid-byte
        load_byte(8'hC3);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.mosi = 1'b1;
        cyc(2 * H);
        for (int i = 0; i < 3; i++) begin
            cyc(H);
            bus.sclk = 1'b1;
            cyc(H);
            bus.sclk = 1'b0;
        end
        cyc(H);
        check("t6_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_miso", {31'd0, bus.miso}, 32'd0);
        check("t6_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("t6_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("t6_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("t6_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t6_underrun", {31'd0, bus.underrun}, 32'd0);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        mdl_full = 1'b0;
        mdl_underrun = 1'b0;
        exp_rx.delete();
        cyc(4);
        rst = 1'b1;
        cyc(4);
        load_byte(8'h96);
        spi_xfer(16'h0069, 8, 1'b0, 8'h00, mi);
        check("t6_miso_lit", {24'd0, mi[7:0]}, 32'h96);
        check("t6_rx_lit", {24'd0, bus.rx_data}, 32'h69);

        cyc(4);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
